// File: rtl/bus_packetizer_pkg.sv
// Shared types and header field layout for the bus packetizer.
// The header word carries the sequence number, the overflow flag and the beat count.
package bus_packetizer_pkg;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      DROP    = 2'd1,
      HEADER  = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   localparam int unsigned HDR_SEQ_MSB = 31;
   localparam int unsigned HDR_SEQ_LSB = 24;
   localparam int unsigned HDR_ERR_BIT = 23;
   localparam int unsigned HDR_CNT_MSB = 15;

endpackage

// File: rtl/bus_packetizer_if.sv
// Handshake bundle between the serializer, the packetizer and the downstream bus.
// The packetizer connects through the slave modport; its driver uses master.
interface bus_packetizer_if;

   logic        clear__ENA;
   logic        clear__RDY;
   logic        in_enq__ENA;
   logic        in_enq__RDY;
   logic [31:0] in_enq_v;
   logic        in_enq_last;
   logic        out_enq__ENA;
   logic        out_enq__RDY;
   logic [31:0] out_enq_v;

   modport slave (
      input  clear__ENA,
      input  in_enq__ENA,
      input  in_enq_v,
      input  in_enq_last,
      input  out_enq__RDY,
      output clear__RDY,
      output in_enq__RDY,
      output out_enq__ENA,
      output out_enq_v
   );

   modport master (
      output clear__ENA,
      output in_enq__ENA,
      output in_enq_v,
      output in_enq_last,
      output out_enq__RDY,
      input  clear__RDY,
      input  in_enq__RDY,
      input  out_enq__ENA,
      input  out_enq_v
   );

endinterface

// File: rtl/bus_packetizer_packet_buffer.sv
// Payload store: DEPTH x 32 register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module packet_buffer #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_packetizer.sv
// Collects 32-bit beats until the last one, then emits a header word followed by the
// buffered payload. Messages longer than DEPTH are truncated and flagged in the header.
module bus_packetizer
   import bus_packetizer_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             nRST,
   bus_packetizer_if.slave  bus
);

   state_t         state;
   logic [CW-1:0]  count;
   logic [CW-2:0]  rd;
   logic [7:0]     seq;
   logic           err;
   logic [31:0]    rd_data;
   logic [31:0]    hdr;
   logic [31:0]    out_v;
   logic           buf_we;

   assign bus.clear__RDY   = 1'b1;
   assign bus.in_enq__RDY  = (state == FILL) || (state == DROP);
   assign bus.out_enq__ENA = bus.out_enq__RDY && ((state == HEADER) || (state == PAYLOAD));
   assign bus.out_enq_v    = out_v;

   // Writes only happen in FILL, where count is always below DEPTH.
   assign buf_we = bus.in_enq__ENA && (state == FILL);

   packet_buffer #(
      .DEPTH (DEPTH)
   ) u_packet_buffer (
      .CLK   (CLK),
      .we    (buf_we),
      .waddr (count[CW-2:0]),
      .wdata (bus.in_enq_v),
      .raddr (rd),
      .rdata (rd_data)
   );

   always_comb begin
      hdr                           = '0;
      hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]  = seq;
      hdr[HDR_ERR_BIT]              = err;
      hdr[HDR_CNT_MSB:0]            = 16'(count);
   end

   always_comb begin
      out_v = '0;
      unique case (state)
         HEADER:  out_v = hdr;
         PAYLOAD: out_v = rd_data;
         default: out_v = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= FILL;
         count <= '0;
         rd    <= '0;
         seq   <= '0;
         err   <= 1'b0;
      end else if (bus.clear__ENA) begin
         // Abort wins over any handshake in the same cycle; seq is kept.
         state <= FILL;
         count <= '0;
         rd    <= '0;
         err   <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               if (bus.in_enq__ENA) begin
                  count <= count + 1'b1;
                  if (bus.in_enq_last) begin
                     state <= HEADER;
                     err   <= 1'b0;
                  end else if (count == CW'(DEPTH - 1)) begin
                     state <= DROP;
                  end
               end
            end
            DROP: begin
               if (bus.in_enq__ENA && bus.in_enq_last) begin
                  state <= HEADER;
                  err   <= 1'b1;
               end
            end
            HEADER: begin
               if (bus.out_enq__RDY) begin
                  rd    <= '0;
                  state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (bus.out_enq__RDY) begin
                  if ({1'b0, rd} == count - 1'b1) begin
                     state <= FILL;
                     count <= '0;
                     rd    <= '0;
                     err   <= 1'b0;
                     seq   <= seq + 1'b1;
                  end else begin
                     rd <= rd + 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
